// File: rtl/uart_pkg.sv
// Shared UART TX types and defaults. UART_TX_PARITY_EN adds the even-parity state.
package uart_pkg;

  localparam int DEFAULT_CLKS_PER_BIT = 1250;
  localparam int DEFAULT_FIFO_DEPTH   = 4;

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} uart_state_t;
  localparam int FRAME_BITS = 11;
`else
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_state_t;
  localparam int FRAME_BITS = 10;
`endif

  function automatic logic even_parity(input logic [7:0] b);
    return ^b;
  endfunction

endpackage

// File: rtl/uart_tx_fifo_tx_fifo.sv
// Byte FIFO for the UART transmitter: wrap-bit pointers, sticky overflow on dropped writes.
module tx_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic             overflow
);
  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wptr, rptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             do_wr, do_pop;

  assign empty  = (wptr == rptr);
  assign full   = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  // full is the pre-pop view, so a write while full is dropped even if a pop happens too
  assign do_wr  = wr && !full;
  assign do_pop = pop && !empty;
  assign rdata  = mem[rptr[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr     <= '0;
      rptr     <= '0;
      overflow <= 1'b0;
    end else begin
      if (do_wr)      wptr     <= wptr + (AW+1)'(1);
      if (do_pop)     rptr     <= rptr + (AW+1)'(1);
      if (wr && full) overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem[wptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// UART transmitter with input byte FIFO, 8N1 framing, LSB first.
// Define UART_TX_PARITY_EN for 8E1 (even parity bit between data and stop).
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int FIFO_DEPTH   = DEFAULT_FIFO_DEPTH
) (
  input  logic       clock,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_wr,
  output logic       full,
  output logic       empty,
  output logic       overflow,
  output logic       busy,
  output logic       tx
);
  localparam int TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  uart_state_t state, state_nxt;
  logic [TW-1:0] timer, timer_nxt;
  logic [2:0]    bit_idx, idx_nxt;
  logic [7:0]    shreg, sh_nxt;
  logic [7:0]    head;
  logic          pop, tx_nxt, bit_done;
`ifdef UART_TX_PARITY_EN
  logic          par, par_nxt;
`endif

  tx_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_fifo (
    .clk      (clock),
    .rst      (rst),
    .wr       (tx_wr),
    .wdata    (tx_data),
    .pop      (pop),
    .rdata    (head),
    .full     (full),
    .empty    (empty),
    .overflow (overflow)
  );

  assign bit_done = (timer == TW'(CLKS_PER_BIT - 1));
  assign busy     = (state != IDLE);

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      timer   <= '0;
      bit_idx <= '0;
      shreg   <= '0;
      tx      <= 1'b1;
`ifdef UART_TX_PARITY_EN
      par     <= 1'b0;
`endif
    end else begin
      state   <= state_nxt;
      timer   <= timer_nxt;
      bit_idx <= idx_nxt;
      shreg   <= sh_nxt;
      tx      <= tx_nxt;
`ifdef UART_TX_PARITY_EN
      par     <= par_nxt;
`endif
    end
  end

  always_comb begin
    state_nxt = state;
    timer_nxt = timer + TW'(1);
    idx_nxt   = bit_idx;
    sh_nxt    = shreg;
    pop       = 1'b0;
`ifdef UART_TX_PARITY_EN
    par_nxt   = par;
`endif
    case (state)
      IDLE: begin
        timer_nxt = '0;
        if (!empty) begin
          pop       = 1'b1;
          sh_nxt    = head;
          state_nxt = START;
`ifdef UART_TX_PARITY_EN
          par_nxt   = even_parity(head);
`endif
        end
      end
      START: if (bit_done) begin
        timer_nxt = '0;
        idx_nxt   = '0;
        state_nxt = DATA;
      end
      DATA: if (bit_done) begin
        timer_nxt = '0;
        if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
          state_nxt = PARITY;
`else
          state_nxt = STOP;
`endif
        end else begin
          idx_nxt = bit_idx + 3'd1;
          sh_nxt  = {1'b0, shreg[7:1]};
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: if (bit_done) begin
        timer_nxt = '0;
        state_nxt = STOP;
      end
`endif
      STOP: if (bit_done) begin
        timer_nxt = '0;
        state_nxt = IDLE;
      end
      default: begin
        timer_nxt = '0;
        state_nxt = IDLE;
      end
    endcase

    // tx is registered from next-state values so the line is glitch-free
    case (state_nxt)
      START:   tx_nxt = 1'b0;
      DATA:    tx_nxt = sh_nxt[0];
`ifdef UART_TX_PARITY_EN
      PARITY:  tx_nxt = par_nxt;
`endif
      default: tx_nxt = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Scoreboard bench for uart_tx_fifo: frame-level reference model vs. cycle-exact line monitor.
module tb_uart_tx_fifo;
  localparam int CPB   = 20;
  localparam int DEPTH = 4;
`ifdef UART_TX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif
  localparam int FRAME = NBITS * CPB;

  logic       clock = 1'b0;
  logic       rst   = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic       tx_wr = 1'b0;
  logic       full, empty, overflow, busy, tx;

  uart_tx_fifo #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .clock    (clock),
    .rst      (rst),
    .tx_data  (tx_data),
    .tx_wr    (tx_wr),
    .full     (full),
    .empty    (empty),
    .overflow (overflow),
    .busy     (busy),
    .tx       (tx)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [7:0] data;
    int         fall;
  } frame_t;

  logic [7:0] mq[$];
  frame_t     exp_q[$];
  int         cyc = 0;
  int         free_at = 0;
  int         last_fall = 0;
  logic [7:0] last_data = 8'h00;
  bit         ovf_m = 1'b0;
  int         n_cmp = 0;
  int         n_bad = 0;

  task automatic check(input string name, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, act, req);
    end
  endtask

  // Reference: a byte leaves the queue when the line is free; a frame occupies
  // FRAME clocks starting the cycle after the pop, plus one idle clock after.
  bit was_full;
  frame_t nf;
  always @(posedge clock) begin
    if (rst) begin
      mq.delete();
      exp_q.delete();
      free_at = 0;
      ovf_m   = 1'b0;
    end else begin
      was_full = (mq.size() == DEPTH);
      if (cyc >= free_at && mq.size() > 0) begin
        nf.data   = mq.pop_front();
        nf.fall   = cyc + 1;
        last_fall = nf.fall;
        last_data = nf.data;
        exp_q.push_back(nf);
        free_at   = cyc + FRAME + 1;
      end
      if (tx_wr) begin
        if (was_full) ovf_m = 1'b1;
        else          mq.push_back(tx_data);
      end
    end
    cyc++;
  end

  // Monitor: status every cycle, line checked bit by bit against the scoreboard.
  bit         in_frame = 1'b0;
  frame_t     cur;
  logic       bits [11];
  logic [7:0] dec;
  int         fpos, hold_cnt, k;
  always @(negedge clock) begin
    if (rst) begin
      in_frame = 1'b0;
      check("rst_tx",    int'(tx),       1);
      check("rst_busy",  int'(busy),     0);
      check("rst_empty", int'(empty),    1);
      check("rst_full",  int'(full),     0);
      check("rst_ovf",   int'(overflow), 0);
    end else begin
      check("empty",    int'(empty),    int'(mq.size() == 0));
      check("full",     int'(full),     int'(mq.size() == DEPTH));
      check("overflow", int'(overflow), int'(ovf_m));
      check("busy",     int'(busy),     int'(cyc < free_at));
      if (!in_frame && tx == 1'b0) begin
        check("frame_pending", int'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
          cur = exp_q.pop_front();
          check("fall_cycle", cyc, cur.fall);
          bits[0] = 1'b0;
          for (int i = 0; i < 8; i++) bits[i+1] = cur.data[i];
          bits[9]  = 1'b1;
          bits[10] = 1'b1;
          if (NBITS == 11) bits[9] = ^cur.data;
          in_frame = 1'b1;
          fpos     = 0;
          hold_cnt = 0;
          dec      = 8'h00;
        end
      end
      if (in_frame) begin
        k = fpos / CPB;
        if (tx === bits[k]) hold_cnt++;
        if (k >= 1 && k <= 8 && (fpos % CPB) == CPB / 2) dec[k-1] = tx;
        if ((fpos % CPB) == CPB - 1) begin
          check($sformatf("bit%0d_cycles", k), hold_cnt, CPB);
          hold_cnt = 0;
        end
        fpos++;
        if (fpos == FRAME) begin
          check("byte", int'(dec), int'(cur.data));
          in_frame = 1'b0;
        end
      end
    end
  end

  task automatic step();
    @(posedge clock);
    #2;
  endtask

  task automatic wr(input logic [7:0] d);
    tx_data = d;
    tx_wr   = 1'b1;
    step();
    tx_wr   = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((exp_q.size() > 0 || mq.size() > 0 || in_frame || cyc < free_at + 2) && n < 20 * FRAME) begin
      step();
      n++;
    end
    check("drain", exp_q.size() + mq.size() + int'(in_frame), 0);
  endtask

  initial begin
    int n;
    int tgt;
    repeat (3) step();
    rst = 1'b0;
    step();

    // single byte, then a back-to-back burst
    wr(8'hA5);
    wait_idle();
    wr(8'hA5); wr(8'h02); wr(8'hAB);
    wait_idle();

    // six writes while idle: one popped, four queued, one dropped
    for (int i = 1; i <= 6; i++) wr(8'(i));
    wait_idle();

    // reset in the middle of data bit 3 with two bytes still queued
    wr(8'h55); wr(8'h11); wr(8'h22);
    tgt = last_fall + 4 * CPB + CPB / 2;
    n = 0;
    while (cyc < tgt && n < 2 * FRAME) begin
      step();
      n++;
    end
    check("rst_point_reached", int'(cyc == tgt && last_data == 8'h55), 1);
    rst = 1'b1;
    #1;
    check("async_rst_tx",    int'(tx),    1);
    check("async_rst_busy",  int'(busy),  0);
    check("async_rst_empty", int'(empty), 1);
    step(); step();
    rst = 1'b0;
    repeat (3 * FRAME) step();

    // parity-sensitive bytes
    wr(8'h07); wr(8'h03);
    wait_idle();

    // write landing on the last STOP clock of a frame with the FIFO empty
    wr(8'h3C);
    n = 0;
    while (cyc != free_at - 1 && n < 2 * FRAME) begin
      step();
      n++;
    end
    check("stop_end_reached", int'(cyc == free_at - 1), 1);
    tx_data = 8'hC3;
    tx_wr   = 1'b1;
    step();
    tx_wr   = 1'b0;
    wait_idle();

    // randomized traffic with varying write density
    for (int i = 0; i < 1500; i++) begin
      tx_data = 8'($urandom);
      tx_wr   = ($urandom_range(0, 999) < ((i < 750) ? 4 : 40));
      step();
    end
    tx_wr = 1'b0;
    wait_idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/uart_tx_fifo.md
UART_TX_FIFO -- requirements
Module: uart_tx_fifo

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 1250, clocks per UART bit (12 MHz / 9600 baud).
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, byte entries; power of two, 2..16.
REQ-003 SHALL have port clock  input  1  single system clock, all logic on rising edge.
REQ-004 SHALL have port rst  input  1  reset; asynchronous, active-high.
REQ-005 SHALL have port tx_data  input  8  byte to transmit (packet byte from the vector/packet stage).
REQ-006 SHALL have port tx_wr  input  1  write strobe; one byte queued per cycle high.
REQ-007 SHALL have port full  output  1  FIFO holds FIFO_DEPTH bytes.
REQ-008 SHALL have port empty  output  1  FIFO holds zero bytes.
REQ-009 SHALL have port overflow  output  1  sticky; a write was dropped.
REQ-010 SHALL have port busy  output  1  serializer not in IDLE.
REQ-011 SHALL have port tx  output  1  serial line, idle high, 8N1 (8E1 with parity), LSB first.

Function
REQ-012 SHALL implement states IDLE, START, DATA, PARITY (only with UART_TX_PARITY_EN), STOP.
REQ-013 SHALL, in IDLE with empty low, pop the head byte into a shift register and enter START next cycle.
REQ-014 SHALL drive tx low in START, data bit n in DATA (n=0..7), parity in PARITY, high in STOP and IDLE.
REQ-015 SHALL hold every bit for exactly CLKS_PER_BIT clocks via a bit-timer counter cleared on each state/bit change.
REQ-016 SHALL make tx fall exactly 1 clock after the pop cycle; frame = 10 bit times (11 with parity).
REQ-017 SHALL return from STOP to IDLE after one bit time; back-to-back frames separated by exactly 1 idle clock.
REQ-018 SHALL accept tx_wr when full low; byte enters tail, visible to pop next cycle.
REQ-019 SHALL drop tx_wr when full high, even if a pop occurs that same cycle, and set overflow.
REQ-020 SHALL accept a write on an empty FIFO without bypass; pop occurs at earliest next cycle.
REQ-021 SHALL use wrapping read/write pointers one bit wider than log2(FIFO_DEPTH); full/empty from pointer compare.
REQ-022 SHALL leave tx_data/tx_wr changes with no effect on a frame in progress.
REQ-023 SHALL assert busy from the cycle after the pop through the last STOP clock.

Reset
REQ-024 SHALL on rst: state IDLE, tx=1, busy=0, empty=1, full=0, overflow=0, pointers and timer zero.
REQ-025 SHALL abort any frame on rst mid-operation; tx goes high immediately (asynchronously), queued bytes discarded.
REQ-026 SHALL clear overflow only by rst.

Configuration
REQ-027 SHALL, with macro UART_TX_PARITY_EN defined, insert one even-parity bit (XOR of the 8 data bits) between DATA and STOP.
REQ-028 SHALL, without UART_TX_PARITY_EN, omit PARITY state and logic entirely; 8N1 framing.

Structure
REQ-029 SHALL place the state enumeration, DEFAULT_CLKS_PER_BIT=1250 and DEFAULT_FIFO_DEPTH=4 in shared package uart_pkg.
REQ-030 SHALL implement storage as sub-module tx_fifo (write, pop, full, empty, overflow); serializer FSM in uart_tx_fifo.

Verification (CLKS_PER_BIT=1250, 12 MHz clock, 83.3 ns period)
REQ-031 SHALL test: single write 8'hA5 -> tx 0,1,0,1,0,0,1,0,1,1 each 1250 clocks, busy high 12500 clocks, empty=1 after pop.
REQ-032 SHALL test: writes A5,02,AB on consecutive cycles -> three frames, each 1 idle clock apart; decoded bytes A5,02,AB in order.
REQ-033 SHALL test: 6 consecutive writes 01..06 while idle -> 01 popped at once, 02..05 fill FIFO, 06 dropped, overflow=1, 5 frames out.
REQ-034 SHALL test: rst pulse at bit 3 of frame 8'h55 with 2 queued -> tx=1 at once, busy=0, empty=1, no further frames.
REQ-035 SHALL test: UART_TX_PARITY_EN defined, write 8'h07 -> parity bit 1, frame 11 bit times; 8'h03 -> parity bit 0.
REQ-036 SHALL test: write at the cycle of STOP end while FIFO empty -> byte popped the following IDLE cycle, 1-clock gap held.
